// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the canonical NOP and
// instruction size.
package core_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WAIT  = ST_WAIT,
    DRAIN = ST_DRAIN
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(32'(INSTR_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that arrives while
// IF/ID is stalled. Clear wins over load, load wins over pop.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: runs the imem req/gnt/rvalid handshake, drives the
// PC register load and presents fetched words to IF/ID via a one-entry skid buffer.
//
// state | meaning
// IDLE  | single settling cycle after reset release
// REQ   | request at pc while skid is empty; held until granted
// WAIT  | one request outstanding, its response is live
// DRAIN | one request outstanding, its response is stale and dropped
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  import core_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         if_valid_q, if_valid_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  if_instr_q, if_instr_d;

  logic         skid_valid, skid_load, skid_pop, skid_clear;
  logic [31:0]  skid_pc, skid_instr;
  logic         redirect, granted, resp_live, out_free;

  assign redirect  = redirect_valid && (state_q != IDLE);
  assign imem_req  = (state_q == REQ) && !skid_valid;
  assign imem_addr = pc;
  assign granted   = imem_req && imem_gnt;
  assign resp_live = (state_q == WAIT) && imem_rvalid;
  assign out_free  = !if_valid_q || !stall_i;

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    pc_en      = 1'b0;
    pc_next    = pc + 32'(INSTR_BYTES);
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    skid_load  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (granted) begin
          req_pc_d = pc;
          pc_en    = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT:  if (imem_rvalid) state_d = REQ;
      DRAIN: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    // A redirect coinciding with the response retires it, so only a request
    // still in flight needs DRAIN.
    if (redirect) begin
      pc_en      = 1'b1;
      pc_next    = word_align(redirect_target);
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      skid_clear = 1'b1;
      if (granted || ((state_q == WAIT) && !imem_rvalid)) state_d = DRAIN;
    end else if (out_free) begin
      if (skid_valid) begin
        if_valid_d = 1'b1;
        if_pc_d    = skid_pc;
        if_instr_d = skid_instr;
        skid_pop   = 1'b1;
      end else if (resp_live) begin
        if_valid_d = 1'b1;
        if_pc_d    = req_pc_q;
        if_instr_d = imem_rdata;
      end else begin
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
    end else if (resp_live) begin
      skid_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_pc_q   <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= RESET_PC;
      if_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .clear_i (skid_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;

  // rvalid in REQ means memory answered with nothing outstanding. IDLE is exempt:
  // a response to a request issued before reset may still land there.
  always @(posedge clk) begin
    if (rst_n && (state_q == REQ)) assert (!imem_rvalid);
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch stage of the pipelined RV32I core.
- Drives `pc_next` and `pc_en` of the program-counter register and runs the request/grant/response handshake to instruction memory.
- Presents fetched instructions to the IF/ID boundary with a 1-entry skid buffer.
- Handles stalls from the hazard unit and redirects (branch/jump) from EX, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address; must equal the PC register reset value.
- NOP_INSTR, 32'h0000_0013: value driven on `if_instr` when not valid (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- pc  in  32  current PC from the PC register
- pc_next  out  32  next PC value to the PC register
- pc_en  out  1  PC register load enable
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response data valid, in order, at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- stall_i  in  1  IF/ID must hold; output not consumed this cycle
- redirect_valid  in  1  control-flow change from EX
- redirect_target  in  32  redirect address
- if_valid  out  1  IF/ID instruction valid
- if_pc  out  32  PC of the presented instruction
- if_instr  out  32  presented instruction

Behaviour:
- Reset values:
  - state=IDLE; imem_req=0; pc_en=0.
  - if_valid=0; if_pc=RESET_PC; if_instr=NOP_INSTR.
  - Skid buffer empty; outstanding=0.
- States:
  - IDLE: 1 cycle after reset release, then go to REQ.
  - REQ: `imem_req`=1 and `imem_addr`=`pc`.
    - The request is issued only when the skid buffer is empty. Otherwise `imem_req`=0 and the block stays in REQ.
    - Once asserted, `req` and `addr` stay stable until `gnt`.
    - On `gnt`: capture `req_pc`=`pc`, pulse `pc_en`=1 with `pc_next`=`pc`+4, go to WAIT.
  - WAIT: wait for `imem_rvalid`, then go to REQ.
    - If the output is free (`if_valid`==0 or `stall_i`==0), the response loads `if_*` directly.
    - Otherwise the response goes to the skid buffer.
  - DRAIN: wait for `imem_rvalid`, drop the data, go to REQ.
- Output consumption:
  - When `if_valid`=1 and `stall_i`=0, the output is consumed.
  - On the next edge, `if_*` loads from the skid buffer if it is full; else from a same-cycle response; else `if_valid`=0.
  - Response-to-`if_valid` latency is 1 cycle with no stall.
  - Throughput is 1 instruction per 2 cycles minimum (REQ/WAIT alternation).
- Redirect: `redirect_valid` has the highest priority, in any state other than IDLE.
  - `pc_en`=1 with `pc_next`={`redirect_target`[31:2],2'b00}.
  - `if_valid`=0 and the skid buffer is cleared next cycle.
  - From WAIT, or from REQ with `gnt` in the same cycle: go to DRAIN.
  - From REQ without `gnt`: `imem_req` may be dropped; stay in REQ.
  - In DRAIN: stay in DRAIN; a same-cycle `rvalid` is dropped and the block goes to REQ.
  - A redirect overrides `stall_i`.
- `pc_en`=0 and `pc_next`=`pc`+4 in all other cycles.
- Arithmetic: `pc`+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Invariants:
  - At most 1 outstanding request.
  - `if_pc` is always the address actually fetched.
  - `imem_rvalid` outside WAIT/DRAIN is ignored (protocol error; assert in sim).
- Reset mid-operation: immediate return to reset values. A pending memory response after reset is ignored because state=IDLE/REQ.

Decomposition:
- Package `core_pkg`: `fetch_state_t` enum (IDLE, REQ, WAIT, DRAIN), `NOP_INSTR`, `INSTR_BYTES`=4.
- One sub-module `fetch_skid_buf`: 1-entry valid/pc/instr holding register with load/clear/pop.
- FSM and PC control stay in `fetch_sequencer`.

Test Plan:
- Reset then free-run, `gnt`=1 same cycle, `rvalid` 1 cycle later -> `if_pc` sequence 0x0,0x4,0x8; `pc_en` pulses once per grant; `if_instr` matches memory.
- `stall_i`=1 for 5 cycles while a response arrives -> response held in skid, no new `imem_req`; on release `if_pc` advances with no loss or duplicate.
- Redirect to 0x100 in WAIT -> `pc_next`=0x100, `pc_en`=1; old response dropped in DRAIN; next `if_pc`=0x100; `if_valid`=0 in between.
- Redirect with `target`=0x103 during a `gnt` cycle -> `pc_next`=0x100; state DRAIN; the one stale `rvalid` is discarded.
- `pc`=32'hFFFF_FFFC fetch granted -> `pc_next`=32'h0000_0000.
- `rst_n` low while in WAIT with `if_valid`=1 -> next cycle all outputs at reset values; a late `rvalid` does not set `if_valid`.
